// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: shared states, opcodes and select encodings for the multicycle RV32I controller
package riscv_mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_TRAP
  } state_t;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
    ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_SRA = 4'd8,
    ALU_SLTU = 4'd9, ALU_PASSB = 4'd10;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
    OP_I = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011,
    IMM_U = 3'b100;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_A = 2'b10;
  localparam logic [1:0] SRCB_B = 2'b00, SRCB_IMM = 2'b01, SRCB_4 = 2'b10;
  localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10;
endpackage

// File: rtl/riscv_mc_aludec.sv
// riscv_mc_aludec: ALU operation class plus funct fields -> ALUControl and bad-funct flag
module riscv_mc_aludec
  import riscv_mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_r,
  output logic [3:0] alu_control,
  output logic       bad_funct
);
  always_comb begin
    alu_control = ALU_ADD;
    bad_funct = 1'b0;
    if (aluop == ALUOP_SUB) begin
      alu_control = ALU_SUB;
      bad_funct = funct3[2:1] != 2'b00;
    end else if (aluop == ALUOP_FUNCT) begin
      case (funct3)
        3'b000:  alu_control = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_control = ALU_SLL;
        3'b010:  alu_control = ALU_SLT;
        3'b011:  alu_control = ALU_SLTU;
        3'b100:  alu_control = ALU_XOR;
        3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_control = ALU_OR;
        default: alu_control = ALU_AND;
      endcase
    end
  end
endmodule

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller: multicycle RV32I control FSM with memory stall, illegal trap and retire counter
module riscv_mc_controller
  import riscv_mc_pkg::*;
#(
  parameter int TRAP_ON_ILLEGAL = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [3:0]       ALUControl,
  output logic             RegWrite,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrRet
);
  state_t state, next;
  logic pc_update, ir_w, mem_w, reg_w, taken, bad_funct;
  logic [1:0] aluop;
  logic [3:0] dec_ctrl;
  state_t bad_next;
  assign bad_next = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
  assign aluop = (state == S_EXECR || state == S_EXECI) ? ALUOP_FUNCT :
                 (state == S_BRANCH) ? ALUOP_SUB : ALUOP_ADD;
  assign taken = (funct3 == 3'b000) ? Zero : (funct3 == 3'b001) ? ~Zero : 1'b0;
  riscv_mc_aludec u_aludec (
    .aluop(aluop), .funct3(funct3), .funct7b5(funct7b5), .is_r(state == S_EXECR),
    .alu_control(dec_ctrl), .bad_funct(bad_funct)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      InstrRet <= '0;
    end else begin
      state <= next;
      if (state != S_FETCH && next == S_FETCH) InstrRet <= InstrRet + CNT_W'(1);
    end
  end
  always_comb begin
    next = state;
    pc_update = 1'b0;
    ir_w = 1'b0;
    mem_w = 1'b0;
    reg_w = 1'b0;
    AdrSrc = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA = SRCA_PC;
    ALUSrcB = SRCB_B;
    ImmSrc = IMM_I;
    case (state)
      S_FETCH: begin
        ALUSrcB = SRCB_4;
        ResultSrc = RES_ALURESULT;
        ir_w = MemReady;
        pc_update = MemReady;
        next = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // branch/jump target is precomputed here into ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: next = S_MEMADR;
          OP_R:      next = S_EXECR;
          OP_I:      next = S_EXECI;
          OP_BRANCH: next = S_BRANCH;
          OP_JAL:    next = S_JAL;
          OP_JALR:   next = S_JALR;
          OP_LUI:    next = S_LUI;
          OP_AUIPC:  next = S_AUIPC;
          default:   next = bad_next;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ImmSrc = (op == OP_STORE) ? IMM_S : IMM_I;
        next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        next = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w = 1'b1;
        next = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w = 1'b1;
        next = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_A;
        next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
        next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_A;
        next = bad_funct ? bad_next : S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_4;
        pc_update = 1'b1;
        next = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        pc_update = 1'b1;
        next = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcB = SRCB_IMM;
        ImmSrc = IMM_U;
        next = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc = IMM_U;
        next = S_ALUWB;
      end
      default: next = S_TRAP;
    endcase
  end
  assign ALUControl = (state == S_LUI) ? ALU_PASSB : dec_ctrl;
  assign PCWrite = ~reset & (pc_update | (state == S_BRANCH & taken & ~bad_funct));
  assign IRWrite = ~reset & ir_w;
  assign MemWrite = ~reset & mem_w;
  assign RegWrite = ~reset & reg_w;
  assign Illegal = ~reset & (state == S_TRAP);
endmodule

// File: tb/tb_riscv_mc_controller.sv
// tb_riscv_mc_controller: directed self-checking bench for the multicycle controller
module tb_riscv_mc_controller;
  logic clk = 0, reset = 1;
  logic [6:0] op = 0;
  logic [2:0] funct3 = 0;
  logic funct7b5 = 0, Zero = 0, MemReady = 0;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic [31:0] InstrRet;
  logic w_pcw, w_adr, w_mw, w_irw, w_rw, w_ill;
  logic [1:0] w_res, w_sa, w_sb;
  logic [2:0] w_imm;
  logic [3:0] w_ctl, w_InstrRet;
  int checks = 0, errors = 0, exp_ret = 0;

  riscv_mc_controller #(.TRAP_ON_ILLEGAL(1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite), .Illegal(Illegal),
    .InstrRet(InstrRet)
  );
  riscv_mc_controller #(.TRAP_ON_ILLEGAL(1), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(w_pcw), .AdrSrc(w_adr), .MemWrite(w_mw),
    .IRWrite(w_irw), .ResultSrc(w_res), .ALUSrcA(w_sa), .ALUSrcB(w_sb),
    .ImmSrc(w_imm), .ALUControl(w_ctl), .RegWrite(w_rw), .Illegal(w_ill),
    .InstrRet(w_InstrRet)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_ret(input string name);
    checks++;
    if (InstrRet !== 32'(exp_ret)) begin
      errors++;
      $display("FAIL %s: InstrRet=%0d expected %0d", name, InstrRet, exp_ret);
    end
  endtask

  task automatic do_reset;
    reset = 1;
    step;
    reset = 0;
    exp_ret = 0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1; MemReady = 1; op = 7'b0110011;
    step; step;
    checks++;
    if (IRWrite !== 0 || PCWrite !== 0 || MemWrite !== 0 || RegWrite !== 0 || Illegal !== 0) begin
      errors++;
      $display("FAIL reset_enables: pcw=%b irw=%b mw=%b rw=%b ill=%b expected all 0", PCWrite, IRWrite, MemWrite, RegWrite, Illegal);
    end
    check_ret("reset_count");
    reset = 0;
    #1;
    checks++;
    if (IRWrite !== 1 || PCWrite !== 1 || ALUSrcB !== 2'b10 || ResultSrc !== 2'b10 || AdrSrc !== 0) begin
      errors++;
      $display("FAIL reset_fetch: irw=%b pcw=%b srcb=%b res=%b adr=%b expected 1 1 10 10 0", IRWrite, PCWrite, ALUSrcB, ResultSrc, AdrSrc);
    end
  endtask

  task automatic test_add;
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 0; MemReady = 1;
    step;
    checks++;
    if (ALUSrcA !== 2'b01 || ALUSrcB !== 2'b01 || ImmSrc !== 3'b010 || IRWrite !== 0) begin
      errors++;
      $display("FAIL add_decode: srca=%b srcb=%b imm=%b irw=%b expected 01 01 010 0", ALUSrcA, ALUSrcB, ImmSrc, IRWrite);
    end
    step;
    checks++;
    if (ALUSrcA !== 2'b10 || ALUSrcB !== 2'b00 || ALUControl !== 4'd0 || RegWrite !== 0) begin
      errors++;
      $display("FAIL add_execr: srca=%b srcb=%b ctl=%0d rw=%b expected 10 00 0 0", ALUSrcA, ALUSrcB, ALUControl, RegWrite);
    end
    step;
    checks++;
    if (RegWrite !== 1 || ResultSrc !== 2'b00) begin
      errors++;
      $display("FAIL add_aluwb: rw=%b res=%b expected 1 00", RegWrite, ResultSrc);
    end
    check_ret("add_count_before");
    step;
    exp_ret++;
    checks++;
    if (RegWrite !== 0 || IRWrite !== 1) begin
      errors++;
      $display("FAIL add_refetch: rw=%b irw=%b expected 0 1", RegWrite, IRWrite);
    end
    check_ret("add_count_after");
  endtask

  task automatic run_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic [3:0] exp_ctl, input string name);
    op = o; funct3 = f3; funct7b5 = f7; MemReady = 1;
    step;
    step;
    checks++;
    if (ALUControl !== exp_ctl) begin
      errors++;
      $display("FAIL %s: ALUControl=%0d expected %0d", name, ALUControl, exp_ctl);
    end
    step;
    checks++;
    if (RegWrite !== 1) begin
      errors++;
      $display("FAIL %s_wb: RegWrite=%b expected 1", name, RegWrite);
    end
    step;
    exp_ret++;
    check_ret(name);
  endtask

  task automatic test_alu_table;
    run_alu(7'b0110011, 3'b000, 1, 4'd1, "sub");
    run_alu(7'b0110011, 3'b001, 0, 4'd6, "sll");
    run_alu(7'b0110011, 3'b010, 0, 4'd5, "slt");
    run_alu(7'b0110011, 3'b011, 0, 4'd9, "sltu");
    run_alu(7'b0110011, 3'b100, 0, 4'd4, "xor");
    run_alu(7'b0110011, 3'b101, 0, 4'd7, "srl");
    run_alu(7'b0110011, 3'b101, 1, 4'd8, "sra");
    run_alu(7'b0110011, 3'b110, 0, 4'd3, "or");
    run_alu(7'b0110011, 3'b111, 0, 4'd2, "and");
    run_alu(7'b0010011, 3'b000, 1, 4'd0, "addi_f7");
    run_alu(7'b0010011, 3'b101, 1, 4'd8, "srai");
    run_alu(7'b0010011, 3'b101, 0, 4'd7, "srli");
    run_alu(7'b0010011, 3'b001, 0, 4'd6, "slli");
  endtask

  task automatic test_load;
    op = 7'b0000011; funct3 = 3'b010; MemReady = 1;
    step; step;
    checks++;
    if (ImmSrc !== 3'b000 || ALUSrcA !== 2'b10 || ALUSrcB !== 2'b01) begin
      errors++;
      $display("FAIL lw_memadr: imm=%b srca=%b srcb=%b expected 000 10 01", ImmSrc, ALUSrcA, ALUSrcB);
    end
    MemReady = 0;
    step;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (AdrSrc !== 1 || RegWrite !== 0) begin
        errors++;
        $display("FAIL lw_memread%0d: adr=%b rw=%b expected 1 0", i, AdrSrc, RegWrite);
      end
      if (i == 3) MemReady = 1;
      step;
    end
    checks++;
    if (ResultSrc !== 2'b01 || RegWrite !== 1 || AdrSrc !== 0) begin
      errors++;
      $display("FAIL lw_memwb: res=%b rw=%b adr=%b expected 01 1 0", ResultSrc, RegWrite, AdrSrc);
    end
    step;
    exp_ret++;
    checks++;
    if (RegWrite !== 0 || ResultSrc !== 2'b10) begin
      errors++;
      $display("FAIL lw_refetch: rw=%b res=%b expected 0 10", RegWrite, ResultSrc);
    end
    check_ret("lw_count");
  endtask

  task automatic test_store;
    op = 7'b0100011; funct3 = 3'b010; MemReady = 1;
    step; step;
    checks++;
    if (ImmSrc !== 3'b001) begin
      errors++;
      $display("FAIL sw_memadr: ImmSrc=%b expected 001", ImmSrc);
    end
    MemReady = 0;
    step;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (MemWrite !== 1 || AdrSrc !== 1) begin
        errors++;
        $display("FAIL sw_memwrite%0d: mw=%b adr=%b expected 1 1", i, MemWrite, AdrSrc);
      end
      if (i == 1) MemReady = 1;
      step;
    end
    exp_ret++;
    checks++;
    if (MemWrite !== 0 || AdrSrc !== 0) begin
      errors++;
      $display("FAIL sw_done: mw=%b adr=%b expected 0 0", MemWrite, AdrSrc);
    end
    check_ret("sw_count");
  endtask

  task automatic run_branch(input logic [2:0] f3, input logic exp_z1, input logic exp_z0, input string name);
    op = 7'b1100011; funct3 = f3; MemReady = 1; Zero = 0;
    step; step;
    Zero = 1;
    #1;
    checks++;
    if (PCWrite !== exp_z1 || ALUControl !== 4'd1) begin
      errors++;
      $display("FAIL %s_z1: PCWrite=%b ctl=%0d expected %b 1", name, PCWrite, ALUControl, exp_z1);
    end
    Zero = 0;
    #1;
    checks++;
    if (PCWrite !== exp_z0) begin
      errors++;
      $display("FAIL %s_z0: PCWrite=%b expected %b", name, PCWrite, exp_z0);
    end
    step;
  endtask

  task automatic test_branch;
    run_branch(3'b000, 1, 0, "beq");
    exp_ret++;
    check_ret("beq_count");
    run_branch(3'b001, 0, 1, "bne");
    exp_ret++;
    check_ret("bne_count");
    run_branch(3'b100, 0, 0, "blt_bad");
    checks++;
    if (Illegal !== 1) begin
      errors++;
      $display("FAIL bad_branch_trap: Illegal=%b expected 1", Illegal);
    end
    do_reset;
  endtask

  task automatic test_jumps;
    op = 7'b1101111; MemReady = 1;
    step; step;
    checks++;
    if (PCWrite !== 1 || ALUSrcA !== 2'b01 || ALUSrcB !== 2'b10 || ResultSrc !== 2'b00 || RegWrite !== 0) begin
      errors++;
      $display("FAIL jal_state: pcw=%b srca=%b srcb=%b res=%b rw=%b expected 1 01 10 00 0", PCWrite, ALUSrcA, ALUSrcB, ResultSrc, RegWrite);
    end
    step; step;
    exp_ret++;
    check_ret("jal_count");
    op = 7'b1100111; funct3 = 3'b000;
    step; step;
    checks++;
    if (PCWrite !== 1 || ALUSrcA !== 2'b10 || ALUSrcB !== 2'b01 || ImmSrc !== 3'b000 || ResultSrc !== 2'b10) begin
      errors++;
      $display("FAIL jalr_state: pcw=%b srca=%b srcb=%b imm=%b res=%b expected 1 10 01 000 10", PCWrite, ALUSrcA, ALUSrcB, ImmSrc, ResultSrc);
    end
    step; step;
    exp_ret++;
    op = 7'b0110111;
    step; step;
    checks++;
    if (ALUControl !== 4'd10 || ImmSrc !== 3'b100 || ALUSrcB !== 2'b01 || RegWrite !== 0) begin
      errors++;
      $display("FAIL lui_state: ctl=%0d imm=%b srcb=%b rw=%b expected 10 100 01 0", ALUControl, ImmSrc, ALUSrcB, RegWrite);
    end
    step; step;
    exp_ret++;
    op = 7'b0010111;
    step; step;
    checks++;
    if (ALUControl !== 4'd0 || ImmSrc !== 3'b100 || ALUSrcA !== 2'b01 || ALUSrcB !== 2'b01) begin
      errors++;
      $display("FAIL auipc_state: ctl=%0d imm=%b srca=%b srcb=%b expected 0 100 01 01", ALUControl, ImmSrc, ALUSrcA, ALUSrcB);
    end
    step; step;
    exp_ret++;
    check_ret("jumps_count");
  endtask

  task automatic test_illegal;
    int bad = 0;
    op = 7'h7f; MemReady = 1;
    step; step;
    for (int i = 0; i < 20; i++) begin
      if (Illegal !== 1 || PCWrite !== 0 || IRWrite !== 0 || MemWrite !== 0 || RegWrite !== 0 || InstrRet !== 32'(exp_ret)) bad++;
      step;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL trap_hold: %0d of 20 cycles wrong, expected 0", bad);
    end
    reset = 1;
    #1;
    checks++;
    if (Illegal !== 0) begin
      errors++;
      $display("FAIL trap_reset_illegal: Illegal=%b expected 0", Illegal);
    end
    step;
    reset = 0;
    exp_ret = 0;
    #1;
    checks++;
    if (IRWrite !== 1 || Illegal !== 0) begin
      errors++;
      $display("FAIL trap_exit_fetch: irw=%b ill=%b expected 1 0", IRWrite, Illegal);
    end
    check_ret("trap_exit_count");
  endtask

  task automatic test_reset_mid;
    op = 7'b0100011; MemReady = 1;
    step; step;
    MemReady = 0;
    step;
    checks++;
    if (MemWrite !== 1) begin
      errors++;
      $display("FAIL mid_memwrite: MemWrite=%b expected 1", MemWrite);
    end
    reset = 1;
    #1;
    checks++;
    if (MemWrite !== 0) begin
      errors++;
      $display("FAIL mid_reset_mw: MemWrite=%b expected 0", MemWrite);
    end
    step;
    reset = 0;
    exp_ret = 0;
    #1;
    checks++;
    if (MemWrite !== 0 || AdrSrc !== 0 || ALUSrcB !== 2'b10 || IRWrite !== 0) begin
      errors++;
      $display("FAIL mid_release: mw=%b adr=%b srcb=%b irw=%b expected 0 0 10 0", MemWrite, AdrSrc, ALUSrcB, IRWrite);
    end
    check_ret("mid_count");
    MemReady = 1;
    step;
    checks++;
    if (ALUSrcA !== 2'b01 || MemWrite !== 0) begin
      errors++;
      $display("FAIL mid_decode: srca=%b mw=%b expected 01 0", ALUSrcA, MemWrite);
    end
    do_reset;
  endtask

  task automatic test_wrap;
    do_reset;
    for (int i = 0; i < 16; i++) begin
      run_alu(7'b0110011, 3'b000, 0, 4'd0, "wrap_add");
      if (i == 14) begin
        checks++;
        if (w_InstrRet !== 4'd15) begin
          errors++;
          $display("FAIL wrap_15: InstrRet=%0d expected 15", w_InstrRet);
        end
      end
    end
    checks++;
    if (w_InstrRet !== 4'd0) begin
      errors++;
      $display("FAIL wrap_0: InstrRet=%0d expected 0", w_InstrRet);
    end
    check_ret("wrap_wide");
  endtask

  initial begin
    test_reset;
    test_add;
    test_alu_table;
    test_load;
    test_store;
    test_branch;
    test_jumps;
    test_illegal;
    test_reset_mid;
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
